// File: rtl/tick_counter.sv
// tick_counter: counts rising edges of a selected divided-clock level while
// the run/pause/idle FSM is in RUN, wrapping from TERM back to 0.
//
// Optional feature: define TICK_CNT_STICKY_EN to add the sticky overflow
// output ovf, which latches on any wrap and is cleared only by clear or rst.
//
// state_dbg exposes the FSM state for observation (0 IDLE, 1 PAUSE, 2 RUN).
//
// Control handshake: start, stop and clear are plain levels sampled on every
// posedge clk; there is no valid/ready pairing on this block.
module tick_counter #(
    parameter int WIDTH = 8,
    parameter int TERM  = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_2,
    input  logic             clk_4,
    input  logic             clk_6,
    input  logic [1:0]       sel,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             running,
`ifdef TICK_CNT_STICKY_EN
    output logic             ovf,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_W = WIDTH'(TERM);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic             src;
    logic             prev;
    logic [1:0]       sel_q;
    logic             sel_chg;
    logic             edge_e;
    logic [WIDTH-1:0] count_nx;
    logic             wrap_nx;
    logic             running_nx;

    // Select the tick source; code 11 has no source and never ticks.
    always_comb begin
        src = 1'b0;
        case (sel)
            2'b00:   src = clk_2;
            2'b01:   src = clk_4;
            2'b10:   src = clk_6;
            default: src = 1'b0;
        endcase
    end

    // Rising-edge detect, suppressed in the cycle the selection changes so
    // that switching onto a source that is already high gives no false tick.
    always_comb begin
        sel_chg = (sel != sel_q);
        edge_e  = src & ~prev & ~sel_chg;
    end

    // Remember last cycle's source level and selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            sel_q <= 2'b00;
        end else begin
            prev  <= src;
            sel_q <= sel;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state: clear beats stop, stop beats start.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (stop) begin
            if (state == RUN) state_nx = PAUSE;
        end else if (start) begin
            if (state != RUN) state_nx = RUN;
        end
    end

    // Next values of the registered outputs; a tick is only counted when the
    // current state is already RUN, so a start arriving with an edge is not.
    always_comb begin
        count_nx   = count;
        wrap_nx    = 1'b0;
        running_nx = (state_nx == RUN);
        if (clear) begin
            count_nx = '0;
        end else if ((state == RUN) && edge_e) begin
            if (count == TERM_W) begin
                count_nx = '0;
                wrap_nx  = 1'b1;
            end else begin
                count_nx = count + ONE_W;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
        end else begin
            count   <= count_nx;
            tick    <= edge_e;
            wrap    <= wrap_nx;
            running <= running_nx;
        end
    end

`ifdef TICK_CNT_STICKY_EN
    // Sticky overflow flag: set with any wrap, cleared only by clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (clear)   ovf <= 1'b0;
        else if (wrap_nx) ovf <= 1'b1;
    end
`endif

    assign state_dbg = state;

endmodule

// File: doc/tick_counter.md
TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 Parameter WIDTH, default 8, bit width of count; legal range 2..16.
REQ-002 Parameter TERM, default 59, terminal count value; SHALL satisfy 0 < TERM < 2**WIDTH.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clk_2  input  1  divided-by-2 level from the clock divider, synchronous to clk.
REQ-006 clk_4  input  1  divided-by-4 level, synchronous to clk.
REQ-007 clk_6  input  1  divided-by-6 level, synchronous to clk.
REQ-008 sel  input  2  tick source: 00 clk_2, 01 clk_4, 10 clk_6, 11 no source (never ticks).
REQ-009 start  input  1  level; request run.
REQ-010 stop  input  1  level; request pause.
REQ-011 clear  input  1  level; synchronous return to idle, count zeroed.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 tick  output  1  registered one-cycle pulse per rising edge of the selected source.
REQ-014 wrap  output  1  registered one-cycle pulse when count rolls from TERM to 0.
REQ-015 running  output  1  high while the FSM is in RUN.

Function
REQ-016 Internal register prev SHALL hold the previous-cycle sample of the selected source; edge e = src & ~prev, where src is the currently selected input (0 when sel = 11).
REQ-017 tick SHALL be loaded with e every cycle: one-cycle pulse, one clk after the edge on which src is first sampled high.
REQ-018 sel change: in the cycle sel differs from its previous-cycle value, e SHALL be forced 0 and prev SHALL load the new src; no spurious tick.
REQ-019 With free-running divider inputs, tick period SHALL be 2, 4, 6 clk for sel = 00, 01, 10.
REQ-020 FSM states IDLE, PAUSE, RUN; priority clear > stop > start.
REQ-021 IDLE -> RUN on start; RUN -> PAUSE on stop; PAUSE -> RUN on start; any state -> IDLE on clear; otherwise hold.
REQ-022 count SHALL update on the same edge that sets tick, only when current state is RUN, e = 1 and clear = 0.
REQ-023 Update rule: count == TERM -> count <= 0 and wrap <= 1; else count <= count + 1 and wrap <= 0; wrap is 0 in all other cycles.
REQ-024 Simultaneous stop and e in RUN: the tick SHALL be counted and the state SHALL move to PAUSE.
REQ-025 Simultaneous start and e in IDLE or PAUSE: the tick SHALL NOT be counted.
REQ-026 clear SHALL zero count on the next edge regardless of e; wrap SHALL be 0 in that cycle.
REQ-027 PAUSE SHALL hold count; tick SHALL continue to pulse in all states.
REQ-028 running SHALL be a registered decode of state == RUN.

Reset
REQ-029 rst high SHALL immediately force state IDLE, count 0, tick 0, wrap 0, running 0, prev 0, stored sel 00.
REQ-030 Reset mid-run SHALL discard count; after rst deasserts, the first rising edge of src SHALL produce a tick (prev = 0).

Configuration
REQ-031 Macro TICK_CNT_STICKY_EN defined: add output ovf (1 bit), set on any cycle wrap is set, cleared only by clear or rst; reset value 0.
REQ-032 Macro TICK_CNT_STICKY_EN undefined: port ovf SHALL be absent and all other behaviour unchanged.

Verification
REQ-033 Reset, sel = 00, start pulse, divider running -> running = 1 next cycle; count increments every 2 clk; tick high 1 of every 2 cycles.
REQ-034 TERM = 59, sel = 01, run 60 ticks -> count 59 -> 0 with wrap high exactly once, coincident with count = 0; ovf = 1 when the macro is defined.
REQ-035 RUN at count = 5, assert stop in a cycle with e = 1 -> count = 6, state PAUSE; further ticks leave count at 6; start -> counting resumes from 6.
REQ-036 sel switched 00 -> 10 while clk_6 is high -> no tick in the switch cycle; next tick on the next clk_6 rising edge, then every 6 clk.
REQ-037 count = 30 in RUN, assert clear together with e = 1 and start -> count = 0, state IDLE, wrap = 0, ovf cleared.
REQ-038 Assert rst asynchronously between clk edges at count = 17 -> all outputs 0 before the next edge; sel = 11 after release -> tick stays 0 indefinitely.
